// File: rtl/sram_arbiter_if.sv
// Requester handshake and memory control pins for sram_arbiter.
// The bidirectional data bus stays a plain inout port on the arbiter.
interface sram_arbiter_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
);
    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              busy;
    logic              mem_oe;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;

    // master: the arbiter itself; slave: the requesters plus memory model
    modport master (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr,
        output wr_ack, rd_data, rd_valid, busy, mem_oe, mem_we, mem_addr
    );

    modport slave (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr,
        input  wr_ack, rd_data, rd_valid, busy, mem_oe, mem_we, mem_addr
    );
endinterface

// File: rtl/sram_arbiter.sv
// Round-robin write/read arbiter for an asynchronous SRAM buffer, generating
// setup / strobe / hold timing on the memory pins from one down-counter.
module sram_arbiter #(
    parameter int ADDR_W    = 16,
    parameter int DATA_W    = 16,
    parameter int SETUP_CYC = 1,
    parameter int PULSE_CYC = 2,
    parameter int HOLD_CYC  = 1
) (
    input  logic              clk,
    input  logic              reset,
    sram_arbiter_if.master    bus,
    inout  wire  [DATA_W-1:0] mem_data
);
    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SETUP  = 2'd1;
    localparam logic [1:0] STROBE = 2'd2;
    localparam logic [1:0] HOLD   = 2'd3;

    localparam logic OP_READ  = 1'b0;
    localparam logic OP_WRITE = 1'b1;

    localparam int MAX_AB  = (SETUP_CYC > PULSE_CYC) ? SETUP_CYC : PULSE_CYC;
    localparam int MAX_CYC = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
    localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              op;
    logic              last_grant;
    logic              grant_write;
    logic              bus_drive;
    logic [DATA_W-1:0] wdata_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] rd_data_q;
    logic              mem_oe_q;
    logic              mem_we_q;
    logic              wr_ack_q;
    logic              rd_valid_q;
    logic              busy_q;

    // NOTE: combinational logic gets a value on every path; a missing else would infer a latch.
    always_comb begin
        grant_write = 1'b0;
        if (bus.wr_req && (!bus.rd_req || last_grant == OP_READ))
            grant_write = 1'b1;
    end

    // NOTE: all state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            cnt        <= '0;
            op         <= OP_READ;
            last_grant <= OP_READ;
            bus_drive  <= 1'b0;
            wdata_q    <= '0;
            mem_addr_q <= '0;
            rd_data_q  <= '0;
            mem_oe_q   <= 1'b1;
            mem_we_q   <= 1'b1;
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            wr_ack_q   <= 1'b0;
            rd_valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.wr_req || bus.rd_req) begin
                        state      <= SETUP;
                        cnt        <= CNT_W'(SETUP_CYC - 1);
                        op         <= grant_write;
                        last_grant <= grant_write;
                        busy_q     <= 1'b1;
                        bus_drive  <= grant_write;
                        mem_addr_q <= grant_write ? bus.wr_addr : bus.rd_addr;
                        if (grant_write)
                            wdata_q <= bus.wr_data;
                    end
                end
                SETUP: begin
                    if (cnt == '0) begin
                        state    <= STROBE;
                        cnt      <= CNT_W'(PULSE_CYC - 1);
                        mem_we_q <= (op != OP_WRITE);
                        mem_oe_q <= (op != OP_READ);
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                STROBE: begin
                    if (cnt == '0) begin
                        state    <= HOLD;
                        cnt      <= CNT_W'(HOLD_CYC - 1);
                        mem_we_q <= 1'b1;
                        mem_oe_q <= 1'b1;
                        // Sampled while oe is still low, before the strobe rises.
                        if (op == OP_READ)
                            rd_data_q <= mem_data;
                        if (HOLD_CYC == 1) begin
                            wr_ack_q   <= (op == OP_WRITE);
                            rd_valid_q <= (op == OP_READ);
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                HOLD: begin
                    if (cnt == '0) begin
                        state     <= IDLE;
                        busy_q    <= 1'b0;
                        bus_drive <= 1'b0;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                        if (cnt == CNT_W'(1)) begin
                            wr_ack_q   <= (op == OP_WRITE);
                            rd_valid_q <= (op == OP_READ);
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Data is driven only for writes, from SETUP through HOLD, never under oe.
    assign mem_data     = bus_drive ? wdata_q : 'z;

    assign bus.mem_addr = mem_addr_q;
    assign bus.mem_oe   = mem_oe_q;
    assign bus.mem_we   = mem_we_q;
    assign bus.rd_data  = rd_data_q;
    assign bus.rd_valid = rd_valid_q;
    assign bus.wr_ack   = wr_ack_q;
    assign bus.busy     = busy_q;
endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: vector table of single transactions
// plus hand-written reset, contention and late-input-change sequences.
module tb_sram_arbiter;
    logic        clk = 1'b0;
    logic        reset;
    wire  [15:0] mem_data;

    sram_arbiter_if #(.ADDR_W(16), .DATA_W(16)) bus ();

    sram_arbiter #(
        .ADDR_W(16), .DATA_W(16), .SETUP_CYC(1), .PULSE_CYC(2), .HOLD_CYC(1)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .mem_data (mem_data)
    );

    always #5 clk = ~clk;

    // Memory model: answers reads while oe is low, stores on the rising we edge.
    logic [15:0] mem_model [0:65535];
    assign mem_data = bus.mem_oe ? 16'hzzzz : mem_model[bus.mem_addr];

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Pin-timing monitor, evaluated on the falling edge.
    int          setup_n, strobe_n, hold_n, viol;
    logic        we_seen, oe_seen, prev_busy, prev_we, prev_drive;
    logic [15:0] addr0, data0;

    initial begin
        viol = 0; setup_n = 0; strobe_n = 0; hold_n = 0;
        we_seen = 1'b0; oe_seen = 1'b0;
        prev_busy = 1'b0; prev_we = 1'b1; prev_drive = 1'b0;
        addr0 = '0; data0 = '0;
    end

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            if (!bus.mem_oe && !bus.mem_we) viol++;
            if (!bus.mem_oe && dut.bus_drive) viol++;
            if (bus.busy) begin
                if (!prev_busy) begin
                    addr0 = bus.mem_addr;
                    setup_n = 0; strobe_n = 0; hold_n = 0;
                    we_seen = 1'b0; oe_seen = 1'b0;
                end else if (bus.mem_addr != addr0) begin
                    viol++;
                end
                if (bus.mem_oe && bus.mem_we) begin
                    if (strobe_n == 0) setup_n++;
                    else hold_n++;
                end else begin
                    strobe_n++;
                    if (!bus.mem_we) we_seen = 1'b1;
                    if (!bus.mem_oe) oe_seen = 1'b1;
                end
            end
            if (dut.bus_drive && !prev_drive) data0 = mem_data;
            else if (dut.bus_drive && mem_data != data0) viol++;
            if (!prev_we && bus.mem_we && bus.busy) mem_model[bus.mem_addr] = mem_data;
        end
        prev_busy  = bus.busy;
        prev_we    = bus.mem_we;
        prev_drive = dut.bus_drive;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Issue one request from an idle DUT, return cycles until ack/valid.
    task automatic run_xact(input logic is_wr, input logic [15:0] a, input logic [15:0] d,
                            output int lat);
        logic got;
        got = 1'b0;
        lat = 0;
        if (is_wr) begin
            bus.wr_addr = a; bus.wr_data = d; bus.wr_req = 1'b1;
        end else begin
            bus.rd_addr = a; bus.rd_req = 1'b1;
        end
        while (!got && lat < 20) begin
            tick();
            lat++;
            if (is_wr ? bus.wr_ack : bus.rd_valid) got = 1'b1;
        end
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b0;
        if (!got) check("ack_timeout", 32'(lat), 32'd4);
    endtask

    typedef struct {
        logic        is_wr;
        logic [15:0] addr;
        logic [15:0] data;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int lat;
        int cyc;
        int n_ev;
        string order;
        int ev_cyc [4];

        vecs[0] = '{1'b1, 16'h0010, 16'hA5A5, 16'h0000};
        vecs[1] = '{1'b0, 16'h0010, 16'h0000, 16'hA5A5};
        vecs[2] = '{1'b1, 16'hFFFF, 16'h1234, 16'h0000};
        vecs[3] = '{1'b0, 16'hFFFF, 16'h0000, 16'h1234};
        vecs[4] = '{1'b0, 16'h0000, 16'h0000, 16'h5A5A};
        vecs[5] = '{1'b1, 16'h8001, 16'h00FF, 16'h0000};
        vecs[6] = '{1'b0, 16'h8001, 16'h0000, 16'h00FF};

        for (int i = 0; i < 65536; i++) mem_model[i] = 16'h0000;
        mem_model[0] = 16'h5A5A;

        reset = 1'b0;
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        bus.wr_addr = '0; bus.wr_data = '0; bus.rd_addr = '0;
        repeat (3) tick();

        check("rst_busy",     32'(bus.busy),      32'd0);
        check("rst_mem_oe",   32'(bus.mem_oe),    32'd1);
        check("rst_mem_we",   32'(bus.mem_we),    32'd1);
        check("rst_mem_addr", 32'(bus.mem_addr),  32'd0);
        check("rst_rd_data",  32'(bus.rd_data),   32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid),  32'd0);
        check("rst_wr_ack",   32'(bus.wr_ack),    32'd0);
        check("rst_bus_free", 32'(dut.bus_drive), 32'd0);

        reset = 1'b1;
        tick();

        for (int i = 0; i < 7; i++) begin
            run_xact(vecs[i].is_wr, vecs[i].addr, vecs[i].data, lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'd4);
            check($sformatf("v%0d_setup", i), 32'(setup_n), 32'd1);
            check($sformatf("v%0d_strobe", i), 32'(strobe_n), 32'd2);
            check($sformatf("v%0d_hold", i), 32'(hold_n), 32'd1);
            check($sformatf("v%0d_we_used", i), 32'(we_seen), 32'(vecs[i].is_wr));
            check($sformatf("v%0d_oe_used", i), 32'(oe_seen), 32'(!vecs[i].is_wr));
            if (vecs[i].is_wr)
                check($sformatf("v%0d_mem", i), 32'(mem_model[vecs[i].addr]), 32'(vecs[i].data));
            else
                check($sformatf("v%0d_rd_data", i), 32'(bus.rd_data), 32'(vecs[i].exp_rd));
            tick();
            check($sformatf("v%0d_pulse_once", i), 32'(bus.wr_ack | bus.rd_valid), 32'd0);
        end

        // Write whose wr_data changes one cycle after grant.
        bus.wr_addr = 16'h0200; bus.wr_data = 16'h0F0F; bus.wr_req = 1'b1;
        tick();
        bus.wr_data = 16'hFFFF;
        lat = 1;
        while (!bus.wr_ack && lat < 20) begin
            tick();
            lat++;
        end
        bus.wr_req = 1'b0;
        check("late_change_latency", 32'(lat), 32'd4);
        check("late_change_mem", 32'(mem_model[16'h0200]), 32'h0F0F);
        tick();

        // Reset during STROBE of a write.
        bus.wr_addr = 16'h0300; bus.wr_data = 16'hBEEF; bus.wr_req = 1'b1;
        tick();
        tick();
        check("midrst_in_strobe", 32'(bus.mem_we), 32'd0);
        reset = 1'b0;
        bus.wr_req = 1'b0;
        tick();
        check("midrst_mem_we",   32'(bus.mem_we),    32'd1);
        check("midrst_mem_oe",   32'(bus.mem_oe),    32'd1);
        check("midrst_bus_free", 32'(dut.bus_drive), 32'd0);
        check("midrst_busy",     32'(bus.busy),      32'd0);
        check("midrst_wr_ack",   32'(bus.wr_ack),    32'd0);

        // Contention from reset release: last_grant is back to READ, so W wins first.
        bus.wr_addr = 16'h0400; bus.wr_data = 16'h1111; bus.wr_req = 1'b1;
        bus.rd_addr = 16'h0010; bus.rd_req = 1'b1;
        tick();
        reset = 1'b1;
        cyc = 0; n_ev = 0; order = "";
        while (n_ev < 4 && cyc < 40) begin
            tick();
            cyc++;
            if (bus.wr_ack) begin
                order = {order, "W"}; ev_cyc[n_ev] = cyc; n_ev++;
            end
            if (bus.rd_valid) begin
                order = {order, "R"}; ev_cyc[n_ev] = cyc;
                check($sformatf("cont_rd%0d_data", n_ev), 32'(bus.rd_data), 32'hA5A5);
                n_ev++;
            end
        end
        bus.wr_req = 1'b0; bus.rd_req = 1'b0;
        check("cont_events", 32'(n_ev), 32'd4);
        n_cmp++;
        if (order != "WRWR") begin
            n_bad++;
            $display("FAIL cont_order: got %s expected WRWR", order);
        end
        for (int k = 0; k < 4 && k < n_ev; k++)
            check($sformatf("cont_ack%0d_cycle", k), 32'(ev_cyc[k]), 32'(4 + 5 * k));
        check("cont_mem", 32'(mem_model[16'h0400]), 32'h1111);
        tick();

        // No stray ack from the dropped write, and the bus stays quiet.
        cyc = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.wr_ack || bus.rd_valid || bus.busy) cyc++;
        end
        check("idle_quiet", 32'(cyc), 32'd0);
        check("midrst_no_write", 32'(mem_model[16'h0300]), 32'h0000);
        check("pin_rule_violations", 32'(viol), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
